bcd_display_mux: RTL and testbench

Downstream display stage for the ALU result. Accepts an unsigned binary magnitude plus a sign flag via a valid strobe. Converts the magnitude to two BCD digits with a sequential double-dabble engine. Time-multiplexes the digits onto a two-digit common-anode seven-segment display (active-low sseg/an).

---
 rtl/bcd_display_mux.sv | 193 +++++++++++++++++++
 tb/tb_bcd_display_mux.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_mux.sv
// Binary magnitude + sign to two BCD digits (sequential double dabble), scanned onto a
// two-digit common-anode seven-segment display. Optional build macro: LEADING_ZERO_BLANK_EN.
module bcd_display_mux #(
    parameter int DATA_W      = 6,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_neg,
    output logic              busy,
    output logic              neg,
    output logic [0:6]        sseg,
    output logic [1:0]        an
);
    localparam int SR_W  = DATA_W + 8;
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [0:6] SEG_OFF  = 7'b1111111;
    localparam logic [0:6] SEG_DASH = 7'b1111110;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    function automatic logic [0:6] seg_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return SEG_OFF;
        endcase
    endfunction

    function automatic logic [3:0] dabble_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    state_t            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d, sr_adj;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              sign_q, sign_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic              pend_neg_q, pend_neg_d;
    logic [3:0]        tens_q, tens_d;
    logic [3:0]        units_q, units_d;
    logic              neg_q, neg_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sel_q, sel_d;
    logic [1:0]        an_q, an_d;
    logic [0:6]        sseg_q, sseg_d;
    logic [0:6]        tens_seg;

    // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bit_d       = bit_q;
        sign_d      = sign_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        pend_neg_d  = pend_neg_q;
        tens_d      = tens_q;
        units_d     = units_q;
        neg_d       = neg_q;
        sr_adj      = sr_q;

        // Requests arriving while a conversion is in flight overwrite the single pending slot.
        if (in_valid && state_q != IDLE) begin
            pend_d      = 1'b1;
            pend_data_d = in_data;
            pend_neg_d  = in_neg;
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d    = {8'd0, in_data};
                    sign_d  = in_neg;
                    bit_d   = '0;
                    pend_d  = 1'b0;
                    state_d = SHIFT;
                end else if (pend_q) begin
                    sr_d    = {8'd0, pend_data_q};
                    sign_d  = pend_neg_q;
                    bit_d   = '0;
                    pend_d  = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_adj[SR_W-1 -: 4] = dabble_adjust(sr_q[SR_W-1 -: 4]);
                sr_adj[SR_W-5 -: 4] = dabble_adjust(sr_q[SR_W-5 -: 4]);
                sr_d  = sr_adj << 1;
                bit_d = bit_q + BIT_W'(1);
                if (bit_q == BIT_W'(DATA_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                tens_d  = sr_q[SR_W-1 -: 4];
                units_d = sr_q[SR_W-5 -: 4];
                neg_d   = sign_q;
                if (pend_q) begin
                    sr_d    = {8'd0, pend_data_q};
                    sign_d  = pend_neg_q;
                    bit_d   = '0;
                    pend_d  = in_valid;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // Segments are built from the next digit values so they change on the same edge as neg.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        sel_d = sel_q;
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            sel_d = ~sel_q;
        end

`ifdef LEADING_ZERO_BLANK_EN
        tens_seg = (tens_d == 4'd0) ? SEG_OFF : seg_encode(tens_d);
`else
        tens_seg = seg_encode(tens_d);
`endif
        if (neg_d && tens_d == 4'd0) begin
            tens_seg = SEG_DASH;
        end

        an_d   = sel_q ? 2'b01 : 2'b10;
        sseg_d = sel_q ? tens_seg : seg_encode(units_d);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            bit_q       <= '0;
            sign_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            pend_neg_q  <= 1'b0;
            tens_q      <= 4'd0;
            units_q     <= 4'd0;
            neg_q       <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            an_q        <= 2'b11;
            sseg_q      <= SEG_OFF;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_q       <= bit_d;
            sign_q      <= sign_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            pend_neg_q  <= pend_neg_d;
            tens_q      <= tens_d;
            units_q     <= units_d;
            neg_q       <= neg_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            an_q        <= an_d;
            sseg_q      <= sseg_d;
        end
    end

    assign busy = busy_q;
    assign neg  = neg_q;
    assign sseg = sseg_q;
    assign an   = an_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Self-checking bench for bcd_display_mux: cycle model from timing/arithmetic rules plus
// directed vectors with hand-computed segment patterns.
module tb_bcd_display_mux;
    localparam int DATA_W      = 6;
    localparam int REFRESH_DIV = 4;

    localparam logic [0:6] S_OFF  = 7'b1111111;
    localparam logic [0:6] S_DASH = 7'b1111110;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [0:6] S_TENS_ZERO = 7'b1111111;
`else
    localparam logic [0:6] S_TENS_ZERO = 7'b0000001;
`endif

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_neg;
    logic              busy;
    logic              neg;
    logic [0:6]        sseg;
    logic [1:0]        an;

    int n_checks = 0;
    int n_errors = 0;

    logic [0:6] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    bcd_display_mux #(.DATA_W(DATA_W), .REFRESH_DIV(REFRESH_DIV)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_neg(in_neg),
        .busy(busy), .neg(neg), .sseg(sseg), .an(an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a request accepted at edge s keeps busy high for cycles s..s+DATA_W and its
    // value becomes visible from cycle s+DATA_W+1; the scan phase depends only on cycles
    // elapsed since reset release.
    int  m_edge = 0;
    bit  m_ready = 0;
    bit  m_in_rst = 1;
    int  m_j = 0;
    bit  m_have = 0;
    int  m_start = 0;
    int  m_conv_val = 0;
    bit  m_conv_neg = 0;
    bit  m_pend = 0;
    int  m_pend_val = 0;
    bit  m_pend_neg = 0;
    int  m_val = 0;
    bit  m_neg = 0;
    bit  m_busy = 0;

    function automatic logic [1:0] exp_an();
        if (m_in_rst) return 2'b11;
        return (((m_j - 1) / REFRESH_DIV) % 2 != 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [0:6] exp_sseg();
        if (m_in_rst) return S_OFF;
        if (exp_an() == 2'b10) return seg_tab[m_val % 10];
        if (m_neg && m_val <= 9) return S_DASH;
        if (m_val / 10 == 0) return S_TENS_ZERO;
        return seg_tab[m_val / 10];
    endfunction

    initial begin
        forever begin
            bit active, done, old;
            int ov;
            bit on;
            @(posedge clk);
            m_edge++;
            if (!rst) begin
                m_in_rst = 1; m_j = 0; m_have = 0; m_pend = 0;
                m_val = 0; m_neg = 0;
            end else begin
                m_in_rst = 0;
                m_j++;
                active = m_have && (m_edge - 1 >= m_start) && (m_edge - 1 <= m_start + DATA_W);
                done   = active && (m_edge - 1 == m_start + DATA_W);
                if (!active) begin
                    if (in_valid) begin
                        m_have = 1; m_start = m_edge; m_conv_val = int'(in_data); m_conv_neg = in_neg;
                    end else if (m_pend) begin
                        m_have = 1; m_start = m_edge; m_conv_val = m_pend_val; m_conv_neg = m_pend_neg;
                    end
                    m_pend = 0;
                end else begin
                    old = m_pend; ov = m_pend_val; on = m_pend_neg;
                    if (in_valid) begin
                        m_pend = 1; m_pend_val = int'(in_data); m_pend_neg = in_neg;
                    end else if (done && old) begin
                        m_pend = 0;
                    end
                    if (done) begin
                        m_val = m_conv_val; m_neg = m_conv_neg;
                        if (old) begin
                            m_start = m_edge; m_conv_val = ov; m_conv_neg = on;
                        end
                    end
                end
            end
            m_busy = !m_in_rst && m_have && m_edge >= m_start && m_edge <= m_start + DATA_W;
            m_ready = 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_ready) begin
                check("model_busy", {7'd0, busy}, {7'd0, m_busy});
                check("model_neg", {7'd0, neg}, {7'd0, m_neg});
                check("model_an", {6'd0, an}, {6'd0, exp_an()});
                check("model_sseg", {1'b0, sseg}, {1'b0, exp_sseg()});
            end
        end
    end

    task automatic send(input int value, input logic sign);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = DATA_W'(value);
        in_neg   = sign;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_an(input logic [1:0] target);
        for (int i = 0; i < 20; i++) begin
            if (an === target) break;
            @(negedge clk);
        end
        check("wait_an_timeout", {6'd0, an}, {6'd0, target});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (busy === 1'b0) break;
            @(negedge clk);
        end
        check("wait_idle_timeout", {7'd0, busy}, 8'd0);
    endtask

    task automatic check_digits(input string name, input logic [0:6] units_seg,
                                input logic [0:6] tens_seg);
        wait_an(2'b10);
        check({name, "_units"}, {1'b0, sseg}, {1'b0, units_seg});
        wait_an(2'b01);
        check({name, "_tens"}, {1'b0, sseg}, {1'b0, tens_seg});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_neg = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_an", {6'd0, an}, 8'b00000011);
        check("rst_sseg", {1'b0, sseg}, {1'b0, 7'b1111111});
        check("rst_busy", {7'd0, busy}, 8'd0);
        rst = 1'b1;
        @(negedge clk);
        check("release_an", {6'd0, an}, 8'b00000010);
        check("release_sseg", {1'b0, sseg}, {1'b0, 7'b0000001});

        // 49: busy for exactly 7 cycles, result visible at t+8
        send(49, 1'b0);
        check("lat49_busy_1", {7'd0, busy}, 8'd1);
        for (int k = 2; k <= 7; k++) begin
            @(negedge clk);
            check("lat49_busy", {7'd0, busy}, 8'd1);
        end
        @(negedge clk);
        check("lat49_busy_8", {7'd0, busy}, 8'd0);
        check("lat49_sseg_t8", {1'b0, sseg}, {1'b0, (an == 2'b10) ? 7'b0000100 : 7'b1001100});
        check_digits("v49", 7'b0000100, 7'b1001100);

        send(5, 1'b1);
        wait_idle();
        check("v5_neg", {7'd0, neg}, 8'd1);
        check_digits("v5n", 7'b0100100, S_DASH);

        // Abort mid-conversion; neg from the previous commit must clear
        send(55, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_an", {6'd0, an}, 8'b00000011);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_busy", {7'd0, busy}, 8'd0);
        check("abort_neg", {7'd0, neg}, 8'd0);
        check_digits("abort", 7'b0000001, S_TENS_ZERO);
        send(3, 1'b0);
        wait_idle();
        check_digits("v3", 7'b0000110, S_TENS_ZERO);

        // 7, then 63 and 12 while busy: 12 overwrites 63
        send(7, 1'b0);
        send(63, 1'b0);
        send(12, 1'b0);
        wait_idle();
        check_digits("v12", 7'b0010010, 7'b1001111);

        send(21, 1'b0);
        wait_idle();
        wait_an(2'b01);
        wait_an(2'b10);
        for (int i = 0; i < 8; i++) begin
            check("scan_an", {6'd0, an}, {6'd0, (i < 4) ? 2'b10 : 2'b01});
            check("scan_sseg", {1'b0, sseg}, {1'b0, (i < 4) ? 7'b1001111 : 7'b0010010});
            @(negedge clk);
        end

        send(0, 1'b1);
        wait_idle();
        check("v0n_neg", {7'd0, neg}, 8'd1);
        check_digits("v0n", 7'b0000001, S_DASH);

        send(10, 1'b1);
        wait_idle();
        check("v10n_neg", {7'd0, neg}, 8'd1);
        check_digits("v10n", 7'b0000001, 7'b1001111);

        send(63, 1'b0);
        wait_idle();
        check_digits("v63", 7'b0000110, 7'b0100000);

        // Request landing exactly in the DONE cycle goes through the pending slot
        send(40, 1'b0);
        repeat (5) @(negedge clk);
        send(27, 1'b0);
        repeat (20) @(negedge clk);
        check("v27_busy", {7'd0, busy}, 8'd0);
        check_digits("v27", 7'b0001111, 7'b0010010);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
